// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding-request fetcher feeding a small
// instruction queue, with redirect flush and discard of in-flight data.
module instr_fetch_unit #(
  parameter logic [29:0] RESET_WPC = 30'h0,
  parameter int          DEPTH     = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [29:0] i_redirect_wpc,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [29:0] o_add_pc
);
  localparam int PW = (DEPTH > 2) ? 2 : 1;
  localparam int CW = (DEPTH > 3) ? 3 : 2;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD} state_t;

  state_t        r_state;
  logic          r_req;
  logic [29:0]   r_fetch_wpc;
  logic [29:0]   r_hold_wpc;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_rp, r_wp;
  logic [31:0]   r_instr [DEPTH];
  logic [29:0]   r_wpc   [DEPTH];

  logic          w_push, w_pop;
  logic [CW-1:0] w_cnt_next;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_push     = (r_state == S_REQ) && imem_ack && !i_redirect;
  assign w_pop      = o_valid && !i_stall && !i_redirect;
  assign w_cnt_next = r_count + CW'(w_push) - CW'(w_pop);

  // While discarding, the bus keeps the abandoned address; fetch_wpc already
  // holds the redirect target.
  assign imem_req  = r_req;
  assign imem_addr = {(r_state == S_DISCARD) ? r_hold_wpc : r_fetch_wpc, 2'b00};

  assign o_valid  = (r_count != '0);
  assign o_instr  = o_valid ? r_instr[r_rp] : 32'h0;
  assign o_add_pc = o_valid ? r_wpc[r_rp] + 30'd1 : 30'h0;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr[r_wp] <= imem_rdata;
      r_wpc[r_wp]   <= r_fetch_wpc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_req       <= 1'b0;
      r_fetch_wpc <= RESET_WPC;
      r_hold_wpc  <= RESET_WPC;
      r_count     <= '0;
      r_rp        <= '0;
      r_wp        <= '0;
    end else begin
      if (i_redirect) begin
        r_count     <= '0;
        r_rp        <= '0;
        r_wp        <= '0;
        r_fetch_wpc <= i_redirect_wpc;
      end else begin
        if (w_push) begin
          r_wp        <= ptr_inc(r_wp);
          r_fetch_wpc <= r_fetch_wpc + 30'd1;
        end
        if (w_pop) r_rp <= ptr_inc(r_rp);
        r_count <= w_cnt_next;
      end

      case (r_state)
        S_IDLE: begin
          if (i_redirect || (r_count < FULL)) begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
          end
        end
        S_REQ: begin
          if (i_redirect && !imem_ack) begin
            r_state    <= S_DISCARD;
            r_hold_wpc <= r_fetch_wpc;
          end else if (w_push && (w_cnt_next >= FULL)) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
          end
        end
        S_DISCARD: begin
          if (imem_ack) r_state <= S_REQ;
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed cycle-by-cycle bench for instr_fetch_unit (DEPTH=2, RESET_WPC=0).
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        i_stall = 1'b0;
  logic        i_redirect = 1'b0;
  logic [29:0] i_redirect_wpc = '0;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [29:0] o_add_pc;

  int n_chk = 0;
  int n_fail = 0;

  instr_fetch_unit #(.RESET_WPC(30'h0), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .i_stall(i_stall), .i_redirect(i_redirect), .i_redirect_wpc(i_redirect_wpc),
    .o_valid(o_valid), .o_instr(o_instr), .o_add_pc(o_add_pc)
  );

  always #5 clk = ~clk;

  // Memory returns a word tagged with the low half of its byte address.
  assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

  typedef struct {
    logic        rst, ack, stall, redir;
    logic [29:0] rwpc;
    logic        chk;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [29:0] pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, ack, stall, redir, input logic [29:0] rwpc,
                              input logic chk, req, input logic [31:0] addr,
                              input logic valid, input logic [31:0] instr, input logic [29:0] pc);
    vec_t v;
    v.rst = rst; v.ack = ack; v.stall = stall; v.redir = redir; v.rwpc = rwpc;
    v.chk = chk; v.req = req; v.addr = addr; v.valid = valid; v.instr = instr; v.pc = pc;
    return v;
  endfunction

  task automatic cmp(input string name, input int row, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL row %0d %s: got %0h expected %0h", row, name, got, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, check state-derived outputs,
  // then let the rising edge commit.
  task automatic step(input int row, input vec_t v);
    @(negedge clk);
    reset = v.rst; imem_ack = v.ack; i_stall = v.stall;
    i_redirect = v.redir; i_redirect_wpc = v.rwpc;
    #1;
    if (v.chk) begin
      cmp("imem_req",  row, {31'h0, imem_req}, {31'h0, v.req});
      cmp("imem_addr", row, imem_addr, v.addr);
      cmp("o_valid",   row, {31'h0, o_valid}, {31'h0, v.valid});
      cmp("o_instr",   row, o_instr, v.instr);
      cmp("o_add_pc",  row, {2'b0, o_add_pc}, {2'b0, v.pc});
    end
  endtask

  initial begin
    //                rst ack st rd rwpc          chk req addr          vld instr         pc
    vecs.push_back(mk(1, 0, 0, 0, 30'h0,        0, 0, 32'h0,        0, 32'h0,        30'h0));
    vecs.push_back(mk(0, 0, 0, 0, 30'h0,        1, 0, 32'h0,        0, 32'h0,        30'h0));
    vecs.push_back(mk(0, 1, 0, 0, 30'h0,        1, 1, 32'h0,        0, 32'h0,        30'h0));
    vecs.push_back(mk(0, 1, 0, 0, 30'h0,        1, 1, 32'h4,        1, 32'hC0DE0000, 30'h1));
    vecs.push_back(mk(0, 1, 0, 0, 30'h0,        1, 1, 32'h8,        1, 32'hC0DE0004, 30'h2));
    vecs.push_back(mk(0, 1, 1, 0, 30'h0,        1, 1, 32'hC,        1, 32'hC0DE0008, 30'h3));
    vecs.push_back(mk(0, 0, 1, 0, 30'h0,        1, 0, 32'h10,       1, 32'hC0DE0008, 30'h3));
    vecs.push_back(mk(0, 0, 1, 0, 30'h0,        1, 0, 32'h10,       1, 32'hC0DE0008, 30'h3));
    vecs.push_back(mk(0, 0, 0, 0, 30'h0,        1, 0, 32'h10,       1, 32'hC0DE0008, 30'h3));
    vecs.push_back(mk(0, 0, 0, 0, 30'h0,        1, 0, 32'h10,       1, 32'hC0DE000C, 30'h4));
    vecs.push_back(mk(0, 0, 0, 0, 30'h0,        1, 1, 32'h10,       0, 32'h0,        30'h0));
    vecs.push_back(mk(0, 0, 0, 1, 30'h40,       1, 1, 32'h10,       0, 32'h0,        30'h0));
    vecs.push_back(mk(0, 0, 0, 0, 30'h0,        1, 1, 32'h10,       0, 32'h0,        30'h0));
    vecs.push_back(mk(0, 1, 0, 0, 30'h0,        1, 1, 32'h10,       0, 32'h0,        30'h0));
    vecs.push_back(mk(0, 0, 0, 0, 30'h0,        1, 1, 32'h100,      0, 32'h0,        30'h0));
    vecs.push_back(mk(0, 1, 0, 0, 30'h0,        1, 1, 32'h100,      0, 32'h0,        30'h0));
    vecs.push_back(mk(0, 1, 0, 1, 30'h10,       1, 1, 32'h104,      1, 32'hC0DE0100, 30'h41));
    vecs.push_back(mk(0, 0, 0, 0, 30'h0,        1, 1, 32'h40,       0, 32'h0,        30'h0));
    vecs.push_back(mk(0, 0, 0, 1, 30'h3FFFFFFF, 1, 1, 32'h40,       0, 32'h0,        30'h0));
    vecs.push_back(mk(0, 0, 0, 1, 30'h20,       1, 1, 32'h40,       0, 32'h0,        30'h0));
    vecs.push_back(mk(0, 1, 0, 1, 30'h3FFFFFFF, 1, 1, 32'h40,       0, 32'h0,        30'h0));
    vecs.push_back(mk(0, 1, 0, 0, 30'h0,        1, 1, 32'hFFFFFFFC, 0, 32'h0,        30'h0));
    vecs.push_back(mk(0, 0, 0, 0, 30'h0,        1, 1, 32'h0,        1, 32'hC0DEFFFC, 30'h0));
    vecs.push_back(mk(0, 0, 0, 0, 30'h0,        1, 1, 32'h0,        0, 32'h0,        30'h0));

    foreach (vecs[i]) step(i, vecs[i]);

    // Reset with an entry queued and a request outstanding.
    step(100, mk(0, 1, 1, 0, 30'h0, 1, 1, 32'h0, 0, 32'h0,        30'h0));
    step(101, mk(0, 0, 1, 0, 30'h0, 1, 1, 32'h4, 1, 32'hC0DE0000, 30'h1));
    step(102, mk(1, 0, 1, 0, 30'h0, 1, 1, 32'h4, 1, 32'hC0DE0000, 30'h1));
    step(103, mk(0, 0, 0, 0, 30'h0, 1, 0, 32'h0, 0, 32'h0,        30'h0));
    step(104, mk(0, 0, 1, 0, 30'h0, 1, 1, 32'h0, 0, 32'h0,        30'h0));

    // Fill to full under stall, then redirect out of IDLE.
    step(200, mk(0, 1, 1, 0, 30'h0, 1, 1, 32'h0,  0, 32'h0,        30'h0));
    step(201, mk(0, 1, 1, 0, 30'h0, 1, 1, 32'h4,  1, 32'hC0DE0000, 30'h1));
    step(202, mk(0, 0, 1, 1, 30'h7, 1, 0, 32'h8,  1, 32'hC0DE0000, 30'h1));
    step(203, mk(0, 0, 0, 0, 30'h0, 1, 1, 32'h1C, 0, 32'h0,        30'h0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
